// File: rtl/ex_mem_buffer.sv
// ex_mem_buffer: elastic two-entry EX->MEM pipeline register.
// A head register feeds the memory stage and a skid slot absorbs one
// extra entry, so ex_ready comes straight from a flop.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               drop every held entry (branch/jump redirect)
//   ex_valid, alu_ready EX presents an instruction / result is ready
//   ex_*                EX payload (result, store data, pc, rd, ctrl)
//   ex_ready            buffer can accept (skid slot empty)
//   mem_ready           memory stage consumes the head entry
//   mem_valid, mem_*    head entry valid and its payload
//   occupancy           number of held entries (0..2)
//   stall_cnt           saturating count of mem_valid & ~mem_ready
module ex_mem_buffer #(
  parameter int XLEN    = 32,
  parameter int REG_W   = 5,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               ex_valid,
  input  logic               alu_ready,
  input  logic [XLEN-1:0]    ex_alu_result,
  input  logic [XLEN-1:0]    ex_store_data,
  input  logic [XLEN-1:0]    ex_pc,
  input  logic [REG_W-1:0]   ex_rd,
  input  logic [2:0]         ex_funct3,
  input  logic               ex_mem_read,
  input  logic               ex_mem_write,
  input  logic               ex_reg_write,
  output logic               ex_ready,
  input  logic               mem_ready,
  output logic               mem_valid,
  output logic [XLEN-1:0]    mem_alu_result,
  output logic [XLEN-1:0]    mem_store_data,
  output logic [XLEN-1:0]    mem_pc,
  output logic [REG_W-1:0]   mem_rd,
  output logic [2:0]         mem_funct3,
  output logic               mem_mem_read,
  output logic               mem_mem_write,
  output logic               mem_reg_write,
  output logic [1:0]         occupancy,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]  alu;
    logic [XLEN-1:0]  sdata;
    logic [XLEN-1:0]  pc;
    logic [REG_W-1:0] rd;
    logic [2:0]       funct3;
    logic             mrd;
    logic             mwr;
    logic             rwr;
  } ent_t;

  ent_t in_e;
  ent_t head_q;
  ent_t skid_q;

  logic               head_v_q;
  logic               skid_v_q;
  logic [STALL_W-1:0] stall_q;

  logic acc;
  logic drn;
  logic head_free;
  logic stall;
  logic stall_max;

  always_comb begin
    in_e        = '0;
    in_e.alu    = ex_alu_result;
    in_e.sdata  = ex_store_data;
    in_e.pc     = ex_pc;
    in_e.rd     = ex_rd;
    in_e.funct3 = ex_funct3;
    in_e.mrd    = ex_mem_read;
    in_e.mwr    = ex_mem_write;
    in_e.rwr    = ex_reg_write;
  end

  assign ex_ready  = ~skid_v_q;
  assign acc       = ex_valid & alu_ready
                   & ex_ready & ~flush;
  assign drn       = head_v_q & mem_ready;
  assign head_free = ~head_v_q | drn;
  assign stall     = head_v_q & ~mem_ready;
  assign stall_max = &stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      skid_q   <= '0;
      head_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      if (stall && !stall_max)
        stall_q <= stall_q + 1'b1;

      // Flush wins; payloads keep their
      // stale value, only valids drop.
      if (flush) begin
        head_v_q <= 1'b0;
        skid_v_q <= 1'b0;
      end else if (head_free) begin
        if (skid_v_q) begin
          head_q   <= skid_q;
          head_v_q <= 1'b1;
          skid_v_q <= 1'b0;
        end else if (acc) begin
          head_q   <= in_e;
          head_v_q <= 1'b1;
        end else begin
          head_v_q <= 1'b0;
        end
      end else if (acc) begin
        // Head held: acc implies the
        // skid slot is empty.
        skid_q   <= in_e;
        skid_v_q <= 1'b1;
      end
    end
  end

  assign mem_valid      = head_v_q;
  assign mem_alu_result = head_q.alu;
  assign mem_store_data = head_q.sdata;
  assign mem_pc         = head_q.pc;
  assign mem_rd         = head_q.rd;
  assign mem_funct3     = head_q.funct3;
  assign mem_mem_read   = head_q.mrd;
  assign mem_mem_write  = head_q.mwr;
  assign mem_reg_write  = head_q.rwr;
  assign occupancy      = {1'b0, head_v_q}
                        + {1'b0, skid_v_q};
  assign stall_cnt      = stall_q;

endmodule
